responder_resolver: RTL

- Downstream consumer of the CAPP tag register.
- On a start pulse it snapshots the 100 tag bits and reports every tagged word one at a time, lowest index first, over a valid/ready handshake.
- Each reported tag is retired from the snapshot after its handshake.
- Used by the controller to read or write the responders of a search sequentially.

---
 rtl/capp_pkg.sv | 24 ++
 rtl/first_responder_enc.sv | 23 ++
 rtl/responder_resolver.sv | 100 ++++++++++
 3 files changed

// File: rtl/capp_pkg.sv
// Shared constants, resolver state encoding and popcount helper for the CAPP
// tag-resolution path.
package capp_pkg;

  localparam int unsigned N_WORDS = 100;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned CNT_W   = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FINISH  = 2'd2
  } resolver_state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_WORDS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/first_responder_enc.sv
// Lowest-set-bit priority encoder.
// Also flags a non-empty vector and a vector with exactly one bit set.
module first_responder_enc
  import capp_pkg::*;
(
  input  logic [N_WORDS-1:0] vec,
  output logic [IDX_W-1:0]   index,
  output logic               any,
  output logic               onehot_only
);

  // Scan from the top down so the lowest set bit is the last to write index.
  always_comb begin
    index = '0;
    for (int i = N_WORDS - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

  assign any         = |vec;
  assign onehot_only = any && ((vec & (vec - N_WORDS'(1))) == '0);

endmodule

// File: rtl/responder_resolver.sv
// Snapshots the CAPP tag vector on start and reports each tagged word,
// lowest index first, over a valid/ready handshake.
module responder_resolver
  import capp_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_WORDS-1:0] tag_wires,
  input  logic               start,
  input  logic               abort,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDX_W-1:0]   resp_index,
  output logic               resp_last,
  output logic               busy,
  output logic               done,
  output logic               none_found,
  output logic [CNT_W-1:0]   resp_count
);

  resolver_state_t    state_q, state_d;
  logic [N_WORDS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               none_q, none_d;

  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               enc_onehot;

  first_responder_enc u_enc (
    .vec         (pending_q),
    .index       (enc_idx),
    .any         (enc_any),
    .onehot_only (enc_onehot)
  );

  // Next-state and snapshot bookkeeping; abort wins over a same-cycle transfer.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    none_d    = none_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pending_d = tag_wires;
          count_d   = popcount(tag_wires);
          if (tag_wires == '0) begin
            none_d  = 1'b1;
            state_d = FINISH;
          end else begin
            none_d  = 1'b0;
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        if (abort) begin
          pending_d = '0;
          none_d    = 1'b0;
          state_d   = FINISH;
        end else if (resp_ready) begin
          pending_d = pending_q & ~(N_WORDS'(1) << enc_idx);
          if (enc_onehot) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      none_q    <= none_d;
    end
  end

  // Response signals come straight from registered state and pending.
  assign busy       = (state_q == RESOLVE);
  assign resp_valid = busy & enc_any;
  assign resp_index = busy ? enc_idx : '0;
  assign resp_last  = busy & enc_onehot;
  assign done       = (state_q == FINISH);
  assign none_found = none_q;
  assign resp_count = count_q;

endmodule
